// File: rtl/ps2_keyboard.sv
`timescale 1ns/1ps
// ps2_keyboard
// PS/2 keyboard front end. Synchronises the raw PS/2 clock and data lines,
// deserialises 11-bit device-to-host frames (start, 8 data LSB first, odd
// parity, stop) and folds the E0 (extended) and F0 (break) prefixes into
// single 16-bit key events {brk, 6'b0, ext, scancode}. The events are queued
// in a first-word-fall-through FIFO that the CPU pops.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   ren        pop request; pops the head event when valid is high
//   data       head-of-FIFO event, 16'h0000 when empty
//   valid      FIFO non-empty
//   overflow   sticky: an event was dropped because the FIFO was full
//   frame_err  one-cycle pulse on start, parity, stop or timeout error
module ps2_keyboard #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        ren,
    output logic [15:0] data,
    output logic        valid,
    output logic        overflow,
    output logic        frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Synchronisers. Reset to 1 so that release does not look like a fall.
    // ------------------------------------------------------------------
    logic clk_meta, clk_s, clk_prev;
    logic data_meta, data_s;
    logic fall;

    // NOTE: every clocked register uses non-blocking assignments so all flops
    // sample their inputs from the same edge, whatever the statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_meta  <= 1'b1;
            clk_s     <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_s    <= 1'b1;
        end else begin
            clk_meta  <= ps2_clk;
            clk_s     <= clk_meta;
            clk_prev  <= clk_s;
            data_meta <= ps2_data;
            data_s    <= data_meta;
        end
    end

    assign fall = clk_prev & ~clk_s;

    // ------------------------------------------------------------------
    // Frame receiver FSM
    // ------------------------------------------------------------------
    state_t        state, state_next;
    logic [7:0]    shreg;
    logic [2:0]    bitcnt;
    logic          par_bit;
    logic [TW-1:0] timer;
    logic          timeout_hit;
    logic          start_err, stop_good, stop_bad;

    assign timeout_hit = (state != IDLE) && !fall && (timer == TW'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        start_err  = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        if (timeout_hit) begin
            state_next = IDLE;
        end else if (fall) begin
            unique case (state)
                IDLE: begin
                    if (!data_s) state_next = SHIFT;
                    else         start_err  = 1'b1;
                end
                SHIFT: begin
                    if (bitcnt == 3'd7) state_next = PARITY;
                end
                PARITY: state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    // Odd parity: data bits plus parity bit hold an odd number of ones.
                    if (data_s && (^{shreg, par_bit})) stop_good = 1'b1;
                    else                               stop_bad  = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver datapath and prefix decode
    // ------------------------------------------------------------------
    logic        ext, brk;
    logic        push_valid;
    logic [15:0] push_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg      <= '0;
            bitcnt     <= '0;
            par_bit    <= 1'b0;
            timer      <= '0;
            ext        <= 1'b0;
            brk        <= 1'b0;
            frame_err  <= 1'b0;
            push_valid <= 1'b0;
            push_data  <= '0;
        end else begin
            push_valid <= 1'b0;
            frame_err  <= start_err | stop_bad | timeout_hit;

            if (state == IDLE || fall) timer <= '0;
            else                       timer <= timer + TW'(1);

            if (fall && state == IDLE)  bitcnt <= '0;
            if (fall && state == SHIFT) begin
                shreg  <= {data_s, shreg[7:1]};
                bitcnt <= bitcnt + 3'd1;
            end
            if (fall && state == PARITY) par_bit <= data_s;

            if (stop_good) begin
                if (shreg == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shreg == 8'hF0) begin
                    brk <= 1'b1;
                end else begin
                    // The event is staged here and written into the FIFO one
                    // edge later.
                    push_valid <= 1'b1;
                    push_data  <= {brk, 6'b0, ext, shreg};
                    ext        <= 1'b0;
                    brk        <= 1'b0;
                end
            end
            if (stop_bad || timeout_hit) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Event FIFO (first-word-fall-through)
    // ------------------------------------------------------------------
    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;
    logic          full, pop, wr_en;

    assign valid = (count != '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = ren && valid;
    // When full, a simultaneous pop frees the slot being written.
    assign wr_en = push_valid && (!full || pop);
    assign data  = valid ? mem[rptr] : 16'h0000;

    // NOTE: storage is deliberately left without reset; count and pointers
    // define which entries are meaningful, and data is gated by valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + AW'(1);
            if (pop)   rptr <= rptr + AW'(1);
            unique case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_valid && full && !pop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_keyboard.sv
`timescale 1ns/1ps
// Self-checking bench for ps2_keyboard: table of single frames with expected
// events, plus hand-written sequences for latency, overflow, timeout and
// mid-frame reset.
module tb_ps2_keyboard;

    localparam int HALF = 10;   // clk cycles per half PS/2 clock period

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        ren = 1'b0;
    logic [15:0] data;
    logic        valid;
    logic        overflow;
    logic        frame_err;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int err_cnt  = 0;

    ps2_keyboard #(.DEPTH(8), .TIMEOUT(100)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .ren       (ren),
        .data      (data),
        .valid     (valid),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Counts high cycles of frame_err; a one-cycle pulse adds exactly one.
    always @(negedge clk) if (frame_err) err_cnt++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(code[i]);
        send_bit((~^code) ^ bad_par);
        send_bit(~bad_stop);
        @(negedge clk) ps2_data = 1'b1;
    endtask

    task automatic pop();
        @(negedge clk) ren = 1'b1;
        @(negedge clk) ren = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  code;
        bit          bad_par;
        bit          bad_stop;
        bit          exp_valid;
        logic [15:0] exp_data;
        int          exp_err;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int err_before;
        logic [7:0] partial;

        vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 16'h001C, 0};
        vecs[1]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[2]  = '{8'hF0, 1'b0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[3]  = '{8'h75, 1'b0, 1'b0, 1'b1, 16'h8175, 0};
        vecs[4]  = '{8'h75, 1'b0, 1'b0, 1'b1, 16'h0075, 0};
        vecs[5]  = '{8'h1C, 1'b1, 1'b0, 1'b0, 16'h0000, 1};
        vecs[6]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 16'h001C, 0};
        vecs[7]  = '{8'hE0, 1'b0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[8]  = '{8'h1C, 1'b0, 1'b1, 1'b0, 16'h0000, 1};  // bad stop clears ext
        vecs[9]  = '{8'h1C, 1'b0, 1'b0, 1'b1, 16'h001C, 0};
        vecs[10] = '{8'hF0, 1'b0, 1'b0, 1'b0, 16'h0000, 0};
        vecs[11] = '{8'h6B, 1'b0, 1'b0, 1'b1, 16'h806B, 0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 1'b0);
        check("rst_data", data, 16'h0000);
        check("rst_overflow", overflow, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Latency: valid rises on the 4th rising clk after the stop-bit fall.
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(partial_bit(8'h1C, i));
        send_bit(1'b0);                         // parity for 0x1C
        @(negedge clk) ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("lat_valid_3clk", valid, 1'b0);
        @(posedge clk);
        #1 check("lat_valid_4clk", valid, 1'b1);
        check("lat_data", data, 16'h001C);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        pop();
        check("lat_pop_valid", valid, 1'b0);
        check("lat_pop_data", data, 16'h0000);

        // Pop when empty is ignored.
        pop();
        check("underflow_valid", valid, 1'b0);
        check("underflow_count", dut.count, 4'd0);

        // Table-driven frames
        for (int i = 0; i < 12; i++) begin
            err_before = err_cnt;
            send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
            repeat (8) @(negedge clk);
            check($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            check($sformatf("vec%0d_err", i), err_cnt - err_before, vecs[i].exp_err);
            if (valid) pop();
        end

        // Overflow: 9 events into an 8-entry FIFO.
        for (int c = 1; c <= 9; c++) send_frame(8'(c), 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        check("ovf_overflow", overflow, 1'b1);
        check("ovf_count", dut.count, 4'd8);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("ovf_pop%0d", k), data, 16'(k));
            pop();
        end
        check("ovf_empty", valid, 1'b0);
        check("ovf_sticky", overflow, 1'b1);

        // Timeout: start bit plus 3 data bits, then silence.
        err_before = err_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (120) @(negedge clk);
        check("to_err", err_cnt - err_before, 1);
        check("to_state_idle", dut.state, 2'd0);
        check("to_valid", valid, 1'b0);
        send_frame(8'h2A, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        check("to_next_data", data, 16'h002A);
        pop();

        // Reset mid-frame with two events queued.
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        check("mr_queued_count", dut.count, 4'd2);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("mr_valid", valid, 1'b0);
        check("mr_data", data, 16'h0000);
        check("mr_overflow", overflow, 1'b0);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b0);
        repeat (8) @(negedge clk);
        check("mr_next_valid", valid, 1'b1);
        check("mr_next_data", data, 16'h005A);
        check("mr_next_count", dut.count, 4'd1);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    function automatic logic partial_bit(input logic [7:0] code, input int idx);
        return code[idx];
    endfunction

endmodule
